// File: rtl/vec_mult_pipe_pkg.sv
// vec_mult_pipe_pkg: shared defaults, float classes and format helpers for the vector multiplier
package vec_mult_pipe_pkg;
  localparam int D_LEN_DEF = 32;
  localparam int CELL_N_DEF = 8;
  localparam int MULT_LAT_DEF = 4;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int TAG_W_DEF = 4;
  typedef enum logic [1:0] {FP_NORM, FP_ZERO, FP_INF, FP_NAN} fp_cls_t;
  function automatic int exp_w(input int d);
    return d == 16 ? 5 : 8;
  endfunction
  function automatic int man_w(input int d);
    return d == 16 ? 10 : 23;
  endfunction
  function automatic fp_cls_t fp_join(input fp_cls_t x, input fp_cls_t y);
    return (x == FP_NAN || y == FP_NAN || (x == FP_INF && y == FP_ZERO) || (x == FP_ZERO && y == FP_INF)) ? FP_NAN :
           (x == FP_INF || y == FP_INF) ? FP_INF :
           (x == FP_ZERO || y == FP_ZERO) ? FP_ZERO : FP_NORM;
  endfunction
endpackage

// File: rtl/float_mult.sv
// float_mult: pipelined IEEE multiply, round-to-nearest-even, subnormals flushed to zero
module float_mult import vec_mult_pipe_pkg::*; #(
  parameter int D_LEN = D_LEN_DEF,
  parameter int LAT = MULT_LAT_DEF
) (
  input  logic             clk,
  input  logic [D_LEN-1:0] a,
  input  logic [D_LEN-1:0] b,
  output logic [D_LEN-1:0] y
);
  localparam int EW = exp_w(D_LEN);
  localparam int MW = man_w(D_LEN);
  localparam int PW = 2 * MW + 2;
  localparam logic [EW+1:0] BIAS = {3'b0, {(EW-1){1'b1}}};
  localparam logic [EW+1:0] EMAX = {2'b0, {EW{1'b1}}};
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] ma, mb;
  fp_cls_t ca, cb, c1;
  logic s1;
  logic [EW+1:0] e1, ef;
  logic [PW-1:0] p1;
  logic nrm, guard, sticky, rup, ovf, unf;
  logic [MW-1:0] mant;
  logic [MW:0] mr;
  logic [D_LEN-1:0] res;
  logic [D_LEN-1:0] dly [LAT-1];
  assign {ea, ma} = a[D_LEN-2:0];
  assign {eb, mb} = b[D_LEN-2:0];
  assign ca = ea == '0 ? FP_ZERO : &ea ? (|ma ? FP_NAN : FP_INF) : FP_NORM;
  assign cb = eb == '0 ? FP_ZERO : &eb ? (|mb ? FP_NAN : FP_INF) : FP_NORM;
  // stage 1: sign, biased exponent sum, full significand product and operand class
  always_ff @(posedge clk) begin
    s1 <= a[D_LEN-1] ^ b[D_LEN-1];
    e1 <= {2'b0, ea} + {2'b0, eb} - BIAS;
    p1 <= PW'({1'b1, ma}) * PW'({1'b1, mb});
    c1 <= fp_join(ca, cb);
  end
  assign nrm = p1[PW-1];
  assign mant = nrm ? p1[PW-2:MW+1] : p1[PW-3:MW];
  assign guard = nrm ? p1[MW] : p1[MW-1];
  assign sticky = nrm ? |p1[MW-1:0] : |p1[MW-2:0];
  assign rup = guard & (sticky | mant[0]);
  assign mr = {1'b0, mant} + (MW+1)'(rup);
  assign ef = e1 + (EW+2)'(nrm) + (EW+2)'(mr[MW]);
  assign ovf = !ef[EW+1] && ef >= EMAX;
  assign unf = ef[EW+1] || ef == '0;
  assign res = c1 == FP_NAN ? {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}} :
               (c1 == FP_INF || (c1 == FP_NORM && ovf)) ? {s1, {EW{1'b1}}, {MW{1'b0}}} :
               (c1 == FP_ZERO || unf) ? {s1, {(D_LEN-1){1'b0}}} : {s1, ef[EW-1:0], mr[MW-1:0]};
  // remaining latency as a plain delay line so total depth equals LAT
  always_ff @(posedge clk) begin
    dly[0] <= res;
    for (int i = 1; i < LAT - 1; i++) dly[i] <= dly[i-1];
  end
  assign y = dly[LAT-2];
endmodule

// File: rtl/vmp_fifo.sv
// vmp_fifo: first-word-fall-through result FIFO with occupancy count
module vmp_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [CW-1:0] cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign valid = cnt != '0;
  assign dout = valid ? mem[rd_ptr] : '0;
  // storage needs no reset; empty entries are never presented
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt <= (push && !pop) ? cnt + 1'b1 : (pop && !push) ? cnt - 1'b1 : cnt;
    end
  end
endmodule

// File: rtl/vec_mult_pipe.sv
// vec_mult_pipe: lane-parallel float multiplier with masked lanes, broadcast B and credit-based output FIFO
module vec_mult_pipe import vec_mult_pipe_pkg::*; #(
  parameter int D_LEN = D_LEN_DEF,
  parameter int CELL_N = CELL_N_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CELL_N*D_LEN-1:0] in_a,
  input  logic [CELL_N*D_LEN-1:0] in_b,
  input  logic [CELL_N-1:0]       in_mask,
  input  logic                    in_bcast,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CELL_N*D_LEN-1:0] out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_last
);
  localparam int DW = CELL_N * D_LEN;
  localparam int FW = DW + TAG_W + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);
  logic accept, push, pop;
  logic [CW-1:0] inflight_cnt, fifo_cnt;
  logic [MULT_LAT-1:0] vp_v, vp_last;
  logic [CELL_N-1:0] vp_mask [MULT_LAT];
  logic [TAG_W-1:0] vp_tag [MULT_LAT];
  logic [DW-1:0] prod, res;
  logic [FW-1:0] fifo_out;
  assign accept = in_valid & in_ready;
  assign push = vp_v[MULT_LAT-1];
  assign pop = out_valid & out_ready;
  assign in_ready = !rst && ({1'b0, fifo_cnt} + {1'b0, inflight_cnt}) < DEPTH_L;
  for (genvar g = 0; g < CELL_N; g++) begin : g_lane
    logic [D_LEN-1:0] b_sel;
    assign b_sel = in_bcast ? in_b[D_LEN-1:0] : in_b[g*D_LEN +: D_LEN];
    float_mult #(.D_LEN(D_LEN), .LAT(MULT_LAT)) u_mul (
      .clk(clk),
      .a(in_a[g*D_LEN +: D_LEN]),
      .b(b_sel),
      .y(prod[g*D_LEN +: D_LEN])
    );
    assign res[g*D_LEN +: D_LEN] = vp_mask[MULT_LAT-1][g] ? prod[g*D_LEN +: D_LEN] : '0;
  end
  // beat-valid shift register tracking each accepted beat through the multipliers
  always_ff @(posedge clk) begin
    if (rst) vp_v <= '0;
    else vp_v <= {vp_v[MULT_LAT-2:0], accept};
  end
  // sideband travels alongside lane data; only meaningful where vp_v is set
  always_ff @(posedge clk) begin
    vp_mask[0] <= in_mask;
    vp_tag[0] <= in_tag;
    vp_last <= {vp_last[MULT_LAT-2:0], in_last};
    for (int i = 1; i < MULT_LAT; i++) begin
      vp_mask[i] <= vp_mask[i-1];
      vp_tag[i] <= vp_tag[i-1];
    end
  end
  // credits held by beats inside the multiplier pipe, returned when they land in the FIFO
  always_ff @(posedge clk) begin
    if (rst) inflight_cnt <= '0;
    else inflight_cnt <= (accept && !push) ? inflight_cnt + 1'b1 : (push && !accept) ? inflight_cnt - 1'b1 : inflight_cnt;
  end
  vmp_fifo #(.W(FW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din({vp_tag[MULT_LAT-1], vp_last[MULT_LAT-1], res}),
    .pop(pop),
    .dout(fifo_out),
    .valid(out_valid),
    .cnt(fifo_cnt)
  );
  assign {out_tag, out_last, out_data} = fifo_out;
endmodule
